instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, width of the instruction-memory word address (64 entries).
REQ-002 SHALL have ports in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- clear  in  1  synchronous pulse; restarts the write address and clears error.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  3  op_t mnemonic: ADD, SUB, AND, ORR, ADDI, LDUR, STUR, CBZ.
- in_rd  in  5  Rd/Rt field.
- in_rn  in  5  Rn field.
- in_rm  in  5  Rm field; R-format only.
- in_imm  in  19  immediate, two's complement; field used depends on op.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  sink accepts when out_valid & out_ready.
- out_word  out  32  LEGv8 instruction word.
- out_addr  out  ADDR_W  instruction-memory word address for out_word.
- full  out  1  all 2^ADDR_W addresses written.
- err  out  1  sticky: an out-of-range immediate was rejected.

Function
REQ-003 SHALL encode, with all unnamed bits zero:
- R (ADD/SUB/AND/ORR): opcode[31:21], Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0].
- I (ADDI): opcode[31:22]=1001000100, imm12[21:10], Rn, Rd.
- D (LDUR/STUR): opcode[31:21], imm9[20:12], op2[11:10]=00, Rn, Rt.
- CB (CBZ): opcode[31:24]=10110100, imm19[23:5], Rt[4:0]; Rn ignored.
REQ-004 SHALL use the 11-bit opcodes ADD=10001011000, SUB=11001011000, AND=10001010000, ORR=10101010000, LDUR=11111000010, STUR=11111000000; these are the same values the ALU control decoder matches on funct.
REQ-005 SHALL check immediate range:
- ADDI requires in_imm[18:12]==0.
- LDUR/STUR require in_imm[18:8] all equal (fits signed 9-bit).
- R-format and CBZ are always legal.
REQ-006 SHALL handle an illegal request by consuming it, emitting no word, leaving the address unchanged and setting err in the next cycle.
REQ-007 SHALL implement FSM EMPTY, HOLD, FULL:
- EMPTY: out_valid=0, in_ready=1. A legal accept moves to HOLD.
- HOLD: out_valid=1, and out_word/out_addr stay stable until out_ready. in_ready=out_ready.
- HOLD with out_ready: address increments. A simultaneous legal accept stays in HOLD with the new word; otherwise move to EMPTY.
- Any state: when the last address (2^ADDR_W-1) is consumed, move to FULL.
- FULL: in_ready=0, out_valid=0, full=1, until clear.
REQ-008 SHALL have latency of 1 cycle (accept at edge N, out_valid high after edge N), with throughput of one word per cycle when out_ready is held high.
REQ-009 SHALL register out_word and out_addr; no combinational path from in_* to out_*.
REQ-010 SHALL treat clear as top priority in the same cycle: state becomes EMPTY, address 0, err 0, and any concurrent handshake is discarded.
REQ-011 SHALL not wrap the address; wrap-around is prevented by FULL.

Reset
REQ-012 SHALL, on reset low, asynchronously force: state EMPTY, out_addr 0, out_word 0, out_valid 0, full 0, err 0. in_ready is 1 after reset deasserts.
REQ-013 SHALL discard a word held in HOLD when reset is asserted mid-operation; that word is never re-emitted.

Structure
REQ-014 SHALL take op_t and the opcode constants from the shared package, alongside the existing ALU-control macros.
REQ-015 SHALL keep the encoding and range check in one combinational sub-module, instr_pack (in: op, rd, rn, rm, imm; out: word, legal), with the FSM, address counter and output register in instr_encoder.

Verification
REQ-016 SHALL cover:
- ADD rd=1 rn=2 rm=3, out_ready=1 -> out_word 0x8B030041 at out_addr 0, one cycle after accept.
- ADDI rd=9 rn=31 imm=5, then LDUR rd=1 rn=0 imm=8, back-to-back -> 0x910017E9 @0, then 0xF8408001 @1.
- CBZ rd=3 imm=2 with out_ready=0 for 3 cycles -> 0xB4000043 held stable, in_ready=0 until release.
- ADDI imm=4096 -> err=1, no out_valid, next legal word still at the unchanged address.
- 64 legal requests -> full=1 and in_ready=0; then clear -> out_addr 0, full=0.
- Reset asserted during HOLD -> out_valid=0 asynchronously, out_addr 0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the LEGv8 instruction encoder.
// Holds the request mnemonic type, the opcode constants (the same values
// the ALU control decoder matches on funct) and the encoder FSM states.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_LDUR, OP_STUR, OP_CBZ
  } op_t;

  // 11-bit R/D-format opcodes
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // I- and CB-format opcodes are narrower
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_FULL} state_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: purely combinational LEGv8 field packer and immediate range
// check.
//   in : op, rd, rn, rm, imm (19-bit two's complement)
//   out: word (encoded instruction, unnamed bits zero), legal
module instr_pack
  import instr_encoder_pkg::*;
(
  input  op_t         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [18:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic w_imm9_ok;

  // Signed 9-bit fit: every bit from the sign position up must match.
  assign w_imm9_ok = (&imm[18:8]) | ~(|imm[18:8]);

  always_comb begin
    word  = 32'h0;
    legal = 1'b1;
    case (op)
      OP_ADD:  word = {OPC_ADD, rm, 6'd0, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'd0, rn, rd};
      OP_AND:  word = {OPC_AND, rm, 6'd0, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'd0, rn, rd};
      OP_ADDI: begin
        word  = {OPC_ADDI, imm[11:0], rn, rd};
        legal = (imm[18:12] == 7'd0);
      end
      OP_LDUR: begin
        word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        legal = w_imm9_ok;
      end
      OP_STUR: begin
        word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        legal = w_imm9_ok;
      end
      OP_CBZ:  word = {OPC_CBZ, imm, rd};
      default: begin
        word  = 32'h0;
        legal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts LEGv8 assembly requests, encodes them and streams
// the words out with the instruction-memory address they belong at.
//   clk/reset(async, active low)/clear(sync)  : control
//   in_valid/in_ready/in_op/in_rd/in_rn/in_rm/in_imm : request channel
//   out_valid/out_ready/out_word/out_addr            : word channel
//   full : every address written; err : sticky illegal-immediate flag
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_t               in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              r_state, w_nxt_state;
  logic [ADDR_W-1:0]   r_addr,  w_nxt_addr;
  logic [31:0]         r_word;
  logic                r_err;

  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_last, w_accept, w_load, w_err_set;

  instr_pack u_pack (
    .op    (in_op),
    .rd    (in_rd),
    .rn    (in_rn),
    .rm    (in_rm),
    .imm   (in_imm),
    .word  (w_word),
    .legal (w_legal)
  );

  assign w_last = (r_addr == LAST_ADDR);

  always_comb begin
    in_ready    = 1'b0;
    w_nxt_state = r_state;
    w_nxt_addr  = r_addr;
    case (r_state)
      ST_EMPTY: in_ready = 1'b1;
      // A word accepted while the last address drains would have nowhere
      // to go, so hold off the request side for that one cycle.
      ST_HOLD:  in_ready = out_ready & ~w_last;
      default:  in_ready = 1'b0;
    endcase

    w_accept  = in_valid & in_ready;
    w_load    = w_accept & w_legal;
    w_err_set = w_accept & ~w_legal;

    case (r_state)
      ST_EMPTY: if (w_load) w_nxt_state = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          if (w_last) begin
            w_nxt_state = ST_FULL;  // no wrap: stop at the top address
          end else begin
            w_nxt_addr  = r_addr + 1'b1;
            w_nxt_state = w_load ? ST_HOLD : ST_EMPTY;
          end
        end
      end
      default: w_nxt_state = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_addr  <= '0;
      r_word  <= 32'h0;
      r_err   <= 1'b0;
    end else if (clear) begin
      // Clear wins over any handshake in the same cycle.
      r_state <= ST_EMPTY;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_addr  <= w_nxt_addr;
      if (w_load)    r_word <= w_word;
      if (w_err_set) r_err  <= 1'b1;
    end
  end

  assign out_valid = (r_state == ST_HOLD);
  assign full      = (r_state == ST_FULL);
  assign out_word  = r_word;
  assign out_addr  = r_addr;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  op_t         in_op = OP_ADD;
  logic [4:0]  in_rd = '0, in_rn = '0, in_rm = '0;
  logic [18:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic [5:0]  out_addr;
  logic        full, err;

  instr_encoder #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_t         op;
    logic [4:0]  rd, rn, rm;
    logic [18:0] imm;
    logic [31:0] w;
    bit          legal;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  a;
  } exp_t;

  exp_t       sb[$];
  vec_t       tbl[13];
  logic [5:0] exp_addr = '0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: scoreboard check at the negedge, then advance to posedge+1.
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %h @%0d expected none", out_word, out_addr);
      end else begin
        e = sb.pop_front();
        chk("sb_word", out_word, e.w);
        chk("sb_addr", {26'd0, out_addr}, {26'd0, e.a});
      end
    end
    acc = in_valid && in_ready;
    @(posedge clk); #1;
  endtask

  task automatic send(input op_t op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [18:0] imm,
                      input bit push, input logic [31:0] w, output int waits);
    bit acc = 0;
    if (push) begin
      sb.push_back('{w, exp_addr});
      exp_addr++;
    end
    in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    in_valid = 1'b1;
    waits = 0;
    while (!acc && waits < 50) begin
      step(acc);
      waits++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 50");
      if (push) void'(sb.pop_back());
    end
  endtask

  task automatic do_clear();
    bit acc;
    clear = 1'b1;
    step(acc);
    clear = 1'b0;
    exp_addr = '0;
  endtask

  initial begin
    bit acc;
    int n;

    tbl[0]  = '{OP_ADD,  5'd1,  5'd2,  5'd3,  19'd0,       32'h8B030041, 1'b1};
    tbl[1]  = '{OP_ADDI, 5'd9,  5'd31, 5'd0,  19'd5,       32'h910017E9, 1'b1};
    tbl[2]  = '{OP_LDUR, 5'd1,  5'd0,  5'd0,  19'd8,       32'hF8408001, 1'b1};
    tbl[3]  = '{OP_SUB,  5'd4,  5'd5,  5'd6,  19'd0,       32'hCB0600A4, 1'b1};
    tbl[4]  = '{OP_AND,  5'd0,  5'd0,  5'd31, 19'd0,       32'h8A1F0000, 1'b1};
    tbl[5]  = '{OP_ORR,  5'd31, 5'd31, 5'd31, 19'd0,       32'hAA1F03FF, 1'b1};
    tbl[6]  = '{OP_STUR, 5'd2,  5'd3,  5'd0,  19'h7FFFF,   32'hF81FF062, 1'b1};
    tbl[7]  = '{OP_LDUR, 5'd0,  5'd0,  5'd0,  19'h7FF00,   32'hF8500000, 1'b1};
    tbl[8]  = '{OP_ADDI, 5'd0,  5'd0,  5'd0,  19'd4095,    32'h913FFC00, 1'b1};
    tbl[9]  = '{OP_CBZ,  5'd0,  5'd7,  5'd0,  19'h7FFFF,   32'hB4FFFFE0, 1'b1};
    tbl[10] = '{OP_ADDI, 5'd1,  5'd1,  5'd0,  19'd4096,    32'h0,        1'b0};
    tbl[11] = '{OP_LDUR, 5'd1,  5'd1,  5'd0,  19'd256,     32'h0,        1'b0};
    tbl[12] = '{OP_STUR, 5'd1,  5'd1,  5'd0,  19'h7FEFF,   32'h0,        1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_addr",  {26'd0, out_addr},  32'd0);
    chk("rst_out_word",  out_word,           32'd0);
    chk("rst_full",      {31'd0, full},      32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Single ADD: valid one cycle after accept
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1, 32'h8B030041, n);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    step(acc);
    do_clear();

    // Table: back-to-back requests with out_ready high
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm,
           tbl[i].legal, tbl[i].w, n);
      if (i == 2) chk("b2b_waits", n, 32'd1);
      if (!tbl[i].legal) begin
        chk("tbl_err", {31'd0, err}, 32'd1);
        step(acc);
        chk("tbl_no_valid", {31'd0, out_valid}, 32'd0);
        do_clear();
        chk("tbl_err_cleared", {31'd0, err}, 32'd0);
      end
    end
    step(acc);

    // Illegal then legal: address unchanged by the rejected request
    send(OP_ADD, 5'd7, 5'd7, 5'd7, 19'd0, 1'b1, 32'h8B0700E7, n);
    send(OP_ADDI, 5'd1, 5'd1, 5'd0, 19'd4096, 1'b0, 32'h0, n);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_no_valid", {31'd0, out_valid}, 32'd0);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1, 32'h8B030041, n);
    step(acc);
    chk("ill_err_sticky", {31'd0, err}, 32'd1);

    // Backpressure: CBZ held for 3 cycles
    out_ready = 1'b0;
    send(OP_CBZ, 5'd3, 5'd9, 5'd0, 19'd2, 1'b1, 32'hB4000043, n);
    in_op = OP_ADD; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid",    {31'd0, out_valid}, 32'd1);
      chk("hold_word",     out_word,           32'hB4000043);
      chk("hold_in_ready", {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(acc);
    chk("hold_released", {31'd0, out_valid}, 32'd0);
    do_clear();

    // Fill all 64 addresses
    for (int i = 0; i < 64; i++)
      send(OP_ADD, i[4:0], 5'd0, 5'd0, 19'd0, 1'b1, 32'h8B000000 | {27'd0, i[4:0]}, n);
    step(acc);
    chk("full_flag",     {31'd0, full},      32'd1);
    chk("full_in_ready", {31'd0, in_ready},  32'd0);
    chk("full_no_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    step(acc);
    chk("full_no_accept", {31'd0, acc}, 32'd0);
    in_valid = 1'b0;
    do_clear();
    chk("clr_addr",     {26'd0, out_addr}, 32'd0);
    chk("clr_full",     {31'd0, full},     32'd0);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset during HOLD
    out_ready = 1'b0;
    send(OP_ADD, 5'd1, 5'd1, 5'd1, 19'd0, 1'b1, 32'h8B010021, n);
    void'(sb.pop_back());
    exp_addr = '0;
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_addr",  {26'd0, out_addr},  32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    step(acc);
    chk("arst_no_reemit", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready",  {31'd0, in_ready},  32'd1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
